// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared encodings for the parametrised up/down counter family.
//
// Contents:
//   MODE_WRAP / MODE_SAT : values of the `mode` input
//   DIR_UP / DIR_DOWN    : values of the `dir` input
// ---------------------------------------------------------------------------
package counter_pkg;

    // Behaviour at the range boundary: wrap around, or stick at the bound.
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Counting direction.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_updown_mod.sv
// ---------------------------------------------------------------------------
// counter_updown_mod
// Parametrised up/down counter with a runtime-programmable inclusive range
// [0, max_val]. It supports synchronous load (clamped into range), a count
// enable, and wrap or saturate behaviour at the bounds. It also produces a
// registered one-cycle terminal-count pulse for cascading stages.
//
// Parameters:
//   WIDTH     : counter / data width in bits (2..32)
//   RESET_VAL : value taken by `count` on reset (<= 2^WIDTH-1)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-low reset
//   en       in   count enable
//   dir      in   1 = up, 0 = down
//   mode     in   0 = wrap, 1 = saturate
//   load     in   synchronous load strobe (beats en)
//   load_val in   [WIDTH] load value, clamped to max_val
//   max_val  in   [WIDTH] inclusive upper bound, quasi-static
//   count    out  [WIDTH] registered count
//   tc       out  registered pulse, high on the cycle after a wrap step
//   at_bound out  combinational: at the bound in the current direction
// ---------------------------------------------------------------------------
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_bound
);

    localparam logic [WIDTH-1:0] RESET_COUNT = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_next;
    logic             tc_next;

    // Next-state logic. The priority order is load, then enable, then hold.
    // Reset is applied in the register block.
    //
    // The top-of-range case is detected by an explicit compare against
    // max_val. It never relies on count+1 overflowing. This makes
    // max_val = all-ones behave exactly like any other bound.
    //
    // A count above max_val can only happen when max_val was lowered. In
    // that case the count is pulled back to max_val in both modes and both
    // directions.
    always_comb begin
        count_next = count;
        tc_next    = 1'b0;
        if (load) begin
            count_next = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (count > max_val) begin
                count_next = max_val;
            end else if (dir == DIR_UP) begin
                if (count == max_val) begin
                    if (mode == MODE_WRAP) begin
                        count_next = '0;
                        tc_next    = 1'b1;
                    end else begin
                        count_next = max_val;
                    end
                end else begin
                    count_next = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    if (mode == MODE_WRAP) begin
                        count_next = max_val;
                        tc_next    = 1'b1;
                    end else begin
                        count_next = '0;
                    end
                end else begin
                    count_next = count - WIDTH'(1);
                end
            end
        end
    end

    // State register. The synchronous active-low reset overrides load and
    // enable on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= RESET_COUNT;
            tc    <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= tc_next;
        end
    end

    // The bound flag follows count, dir and max_val with no register delay.
    // Downstream logic can therefore see the edge condition in the same
    // cycle it is reached.
    assign at_bound = (dir == DIR_UP) ? (count >= max_val) : (count == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// ---------------------------------------------------------------------------
// tb_counter_updown_mod
// Self-checking bench for counter_updown_mod (WIDTH=8, RESET_VAL=0).
// A modular-arithmetic reference model tracks the expected count and tc.
// A compare process checks every output once per cycle after the first
// reset. Directed vectors also carry hand-worked expected values.
// ---------------------------------------------------------------------------
module tb_counter_updown_mod;

    localparam int WIDTH     = 8;
    localparam int RESET_VAL = 0;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             dir;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             at_bound;

    int n_asserts = 0;
    int n_fail    = 0;

    int m_count = 0;
    int m_tc    = 0;
    bit m_valid = 1'b0;

    counter_updown_mod #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .dir     (dir),
        .mode    (mode),
        .load    (load),
        .load_val(load_val),
        .max_val (max_val),
        .count   (count),
        .tc      (tc),
        .at_bound(at_bound)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value and keep a tally.
    task automatic compareValue(input string name, input int act, input int exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. The range is treated as a ring of max_val+1 values.
    // In wrap mode a step is addition modulo the ring size. In saturate mode
    // the result is clipped into [0, max_val]. tc marks the steps that cross
    // the ring seam.
    always @(posedge clk) begin
        int c;
        int mx;
        int lv;
        int nc;
        int ntc;
        c   = m_count;
        mx  = int'(max_val);
        lv  = int'(load_val);
        nc  = c;
        ntc = 0;
        if (!reset) begin
            nc = RESET_VAL;
        end else if (load) begin
            nc = (lv < mx) ? lv : mx;
        end else if (en) begin
            if (c > mx) begin
                nc = mx;
            end else if (mode == 1'b0) begin
                if (dir) begin
                    nc  = (c + 1) % (mx + 1);
                    ntc = (c == mx) ? 1 : 0;
                end else begin
                    nc  = (c + mx) % (mx + 1);
                    ntc = (c == 0) ? 1 : 0;
                end
            end else begin
                if (dir) nc = (c + 1 > mx) ? mx : c + 1;
                else     nc = (c == 0) ? 0 : c - 1;
            end
        end
        m_count <= nc;
        m_tc    <= ntc;
        if (!reset) m_valid <= 1'b1;
    end

    // Check the DUT against the model on every cycle, just after the edge.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            compareValue("model count", int'(count), m_count);
            compareValue("model tc", int'(tc), m_tc);
            compareValue("model at_bound", int'(at_bound),
                         dir ? ((m_count >= int'(max_val)) ? 1 : 0)
                             : ((m_count == 0) ? 1 : 0));
        end
    end

    // Drive one set of inputs away from the clock edge. Then wait for the
    // edge that consumes them.
    task automatic applyStimulus(input logic r, input logic e, input logic d,
                                 input logic m, input logic l,
                                 input logic [WIDTH-1:0] lv,
                                 input logic [WIDTH-1:0] mv);
        @(negedge clk);
        reset    = r;
        en       = e;
        dir      = d;
        mode     = m;
        load     = l;
        load_val = lv;
        max_val  = mv;
        @(posedge clk);
        #2;
    endtask

    // Check the outputs against hand-worked literal expectations.
    task automatic checkOutput(input string name, input int exp_count,
                               input int exp_tc, input int exp_bound);
        compareValue({name, " count"}, int'(count), exp_count);
        compareValue({name, " tc"}, int'(tc), exp_tc);
        compareValue({name, " at_bound"}, int'(at_bound), exp_bound);
    endtask

    // Watchdog so the bench cannot hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b0; dir = 1'b1; mode = 1'b0;
        load = 1'b0; load_val = '0; max_val = 8'hFF;

        // Reset, then a plain up-count over the full range.
        applyStimulus(0, 0, 1, 0, 0, 8'h00, 8'hFF);
        checkOutput("reset", 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 8'h00, 8'hFF);
            checkOutput("up", i, 0, 0);
        end

        // Wrap mode with max_val=9, first upward and then downward.
        applyStimulus(1, 0, 1, 0, 1, 8'h00, 8'h09);
        checkOutput("load0", 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 8'h00, 8'h09);
            checkOutput("up9", i, 0, (i == 9) ? 1 : 0);
        end
        applyStimulus(1, 1, 1, 0, 0, 8'h00, 8'h09);
        checkOutput("wrap up", 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h09);
        checkOutput("wrap down", 9, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h09);
        checkOutput("down 8", 8, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h09);
        checkOutput("down 7", 7, 0, 0);

        // Saturate mode with max_val=5.
        applyStimulus(1, 0, 1, 1, 1, 8'h03, 8'h05);
        checkOutput("sat load", 3, 0, 0);
        applyStimulus(1, 1, 1, 1, 0, 8'h00, 8'h05);
        checkOutput("sat 4", 4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 1, 0, 8'h00, 8'h05);
            checkOutput("sat hold top", 5, 0, 1);
        end
        applyStimulus(1, 0, 0, 1, 1, 8'h00, 8'h05);
        checkOutput("sat load0", 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 0, 1, 0, 8'h00, 8'h05);
            checkOutput("sat hold zero", 0, 0, 1);
        end

        // Load clamping and the reset/load/enable priority order.
        applyStimulus(1, 0, 1, 0, 1, 8'h20, 8'h10);
        checkOutput("clamp load", 16, 0, 1);
        applyStimulus(1, 1, 1, 0, 1, 8'h03, 8'h10);
        checkOutput("load beats en", 3, 0, 0);
        applyStimulus(0, 1, 1, 0, 1, 8'h44, 8'h10);
        checkOutput("reset beats load", 0, 0, 0);

        // Out-of-range count after max_val is lowered.
        applyStimulus(1, 0, 1, 0, 1, 8'h30, 8'hFF);
        checkOutput("load 30", 48, 0, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h10);
            checkOutput("oor hold", 48, 0, 0);
        end
        applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h10);
        checkOutput("oor pull", 16, 0, 0);

        // Full-range wrap at all-ones.
        applyStimulus(1, 0, 1, 0, 1, 8'hFE, 8'hFF);
        checkOutput("load FE", 254, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 8'h00, 8'hFF);
        checkOutput("up FF", 255, 0, 1);
        applyStimulus(1, 1, 1, 0, 0, 8'h00, 8'hFF);
        checkOutput("wrap FF", 0, 1, 0);

        // Reset asserted mid-count while enabled.
        applyStimulus(1, 0, 1, 0, 1, 8'h07, 8'hFF);
        checkOutput("load 7", 7, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 8'h00, 8'hFF);
        checkOutput("reset mid", 0, 0, 0);

        // Degenerate range with max_val=0.
        applyStimulus(1, 1, 1, 0, 0, 8'h00, 8'h00);
        checkOutput("max0 wrap 1", 0, 1, 1);
        applyStimulus(1, 1, 1, 0, 0, 8'h00, 8'h00);
        checkOutput("max0 wrap 2", 0, 1, 1);
        applyStimulus(1, 1, 1, 1, 0, 8'h00, 8'h00);
        checkOutput("max0 sat", 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 8'h00, 8'h00);
        checkOutput("max0 wrap down", 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h00);
        checkOutput("max0 idle", 0, 0, 1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
